// File: rtl/edge_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : edge_event_arbiter
//  Description : Per-channel rising/falling edge detection with a one-deep
//                pending slot per channel. A round-robin arbiter serialises
//                the pending events onto a single valid/ready event port.
//                Dropped events raise a sticky per-channel overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_event_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_i,
    input  logic [NUM_CH-1:0] rise_en_i,
    input  logic [NUM_CH-1:0] fall_en_i,
    output logic              evt_valid_o,
    input  logic              evt_ready_i,
    output logic [CH_W-1:0]   evt_ch_o,
    output logic              evt_rise_o,
    output logic [NUM_CH-1:0] ovf_o,
    input  logic              ovf_clr_i
);

    // ------------------------------------------------------------------------
    // Output-register state machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;

    // Edge detection
    logic [NUM_CH-1:0] prev;
    logic [NUM_CH-1:0] rise_det;
    logic [NUM_CH-1:0] fall_det;
    logic [NUM_CH-1:0] edge_det;

    // Pending slots
    logic [NUM_CH-1:0] pend_v;
    logic [NUM_CH-1:0] pend_rise;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] capture;
    logic [NUM_CH-1:0] ovf_set;
    logic [NUM_CH-1:0] ovf_flags;

    // Arbitration
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   rr_next;
    logic [CH_W-1:0]   winner;
    logic              any_pend;
    logic              load;
    logic              grant;

    // ------------------------------------------------------------------------
    // Edge detection. prev follows the line every cycle so that toggling an
    // enable never manufactures a stale edge from an old line value.
    // ------------------------------------------------------------------------
    assign rise_det = ~prev &  ch_i & rise_en_i;
    assign fall_det =  prev & ~ch_i & fall_en_i;
    assign edge_det = rise_det | fall_det;

    // Line history register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= '0;
        end else begin
            prev <= ch_i;
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin search starting at rr_ptr, wrapping modulo NUM_CH. The sum
    // is one bit wider than the index so the wrap works for non-power-of-two
    // channel counts.
    // ------------------------------------------------------------------------
    // Select the first pending channel at or after rr_ptr.
    always_comb begin
        logic [CH_W:0]   sum;
        logic [CH_W-1:0] idx;
        logic            found;
        sum    = '0;
        idx    = '0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sum = {1'b0, rr_ptr} + (CH_W+1)'(k);
            if (sum >= (CH_W+1)'(NUM_CH)) begin
                sum = sum - (CH_W+1)'(NUM_CH);
            end
            idx = sum[CH_W-1:0];
            if (!found && pend_v[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign any_pend = |pend_v;

    // The output register may accept a new event when it is empty or when
    // its current event is being taken this cycle.
    assign load    = (state == ST_EMPTY) | evt_ready_i;
    assign grant   = load & any_pend;
    assign rr_next = (winner == CH_W'(NUM_CH - 1)) ? '0 : winner + CH_W'(1);

    // ------------------------------------------------------------------------
    // Per-channel slot control. A popped slot can take a new edge in the same
    // cycle (that is how a short pulse yields rise then fall with no loss);
    // a full, un-popped slot keeps its older event and flags overflow.
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            assign pop[i]     = grant & (winner == CH_W'(i));
            assign capture[i] = edge_det[i] & (~pend_v[i] | pop[i]);
            assign ovf_set[i] = edge_det[i] &   pend_v[i] & ~pop[i];
        end
    endgenerate

    // Pending slot state: popped slots empty, captured edges overwrite.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_v    <= '0;
            pend_rise <= '0;
        end else begin
            pend_v    <= (pend_v & ~pop) | capture;
            pend_rise <= (pend_rise & ~capture) | (rise_det & capture);
        end
    end

    // Sticky overflow flags; a new overflow beats a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_flags <= '0;
        end else begin
            ovf_flags <= (ovf_flags & ~{NUM_CH{ovf_clr_i}}) | ovf_set;
        end
    end

    assign ovf_o = ovf_flags;

    // Round-robin pointer advances past the winner only when it is loaded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= rr_next;
        end
    end

    // ------------------------------------------------------------------------
    // Output register FSM
    // ------------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: fill when anything is pending, drain on a handshake that
    // leaves nothing behind.
    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: begin
                if (any_pend) begin
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (evt_ready_i && !any_pend) begin
                    state_next = ST_EMPTY;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
    end

    assign evt_valid_o = (state == ST_FULL);

    // Event payload; only changes on a grant, so it holds under back-pressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_ch_o   <= '0;
            evt_rise_o <= 1'b0;
        end else if (grant) begin
            evt_ch_o   <= winner;
            evt_rise_o <= pend_rise[winner];
        end
    end

endmodule
`default_nettype wire
